r_mul: RTL

R_MUL -- requirements
Module: r_mul

---
 rtl/r_mul.sv | 118 +++++++++++
 1 files changed

// File: rtl/r_mul.sv
// r_mul: iterative radix-2^RADIX_LOG2 shift-add multiplier computing {p_hi,p_lo} = a*b (+ acc).
// Build option: define R_MUL_ACC_EN to add acc_i into the product; undefined ties the addend to zero.
module r_mul #(
  parameter int N_BITS     = 32,
  parameter int RADIX_LOG2 = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  input  logic [N_BITS-1:0] acc_i,
  output logic [N_BITS-1:0] p_lo_o,
  output logic [N_BITS-1:0] p_hi_o,
  output logic              valid_o,
  output logic              busy_o
);

  localparam int N_STAGES = N_BITS / RADIX_LOG2;
  localparam int CNT_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int SUM_W    = N_BITS + RADIX_LOG2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_STAGES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [N_BITS-1:0]   r_a;
  logic [2*N_BITS-1:0] r_acc;

  logic [N_BITS-1:0]     w_addend;
  logic [RADIX_LOG2-1:0] w_digit;
  logic [SUM_W-1:0]      w_pp_term [RADIX_LOG2];
  logic [SUM_W-1:0]      w_pp;
  logic [SUM_W-1:0]      w_sum;
  logic [2*N_BITS-1:0]   w_acc_next;
  logic [2*N_BITS-1:0]   w_acc_init;

`ifdef R_MUL_ACC_EN
  assign w_addend = acc_i;
`else
  logic w_unused_acc;
  assign w_unused_acc = ^acc_i;
  assign w_addend     = '0;
`endif

  // Upper half starts with the addend: after N_STAGES right shifts it lands in the low half,
  // so the addition costs no extra cycle. Lower half starts with b and is consumed LSB first.
  assign w_acc_init = {w_addend, b_i};
  assign w_digit    = r_acc[RADIX_LOG2-1:0];

  generate
    for (genvar gi = 0; gi < RADIX_LOG2; gi++) begin : g_pp
      assign w_pp_term[gi] = w_digit[gi] ? (SUM_W'(r_a) << gi) : '0;
    end
  endgenerate

  always_comb begin
    w_pp = '0;
    for (int i = 0; i < RADIX_LOG2; i++) begin
      w_pp = w_pp + w_pp_term[i];
    end
  end

  // hi + a*digit <= (2^N-1)*2^R, so SUM_W bits never overflow.
  assign w_sum      = SUM_W'(r_acc[2*N_BITS-1:N_BITS]) + w_pp;
  assign w_acc_next = {w_sum, r_acc[N_BITS-1:RADIX_LOG2]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_acc   <= '0;
      p_lo_o  <= '0;
      p_hi_o  <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FINISH: begin
          valid_o <= 1'b0;
          if (start_i) begin
            r_state <= EXEC;
            busy_o  <= 1'b1;
            r_cnt   <= '0;
            r_a     <= a_i;
            r_acc   <= w_acc_init;
          end else begin
            r_state <= IDLE;
            busy_o  <= 1'b0;
          end
        end
        EXEC: begin
          r_acc <= w_acc_next;
          r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state <= FINISH;
            busy_o  <= 1'b0;
            valid_o <= 1'b1;
            p_hi_o  <= w_acc_next[2*N_BITS-1:N_BITS];
            p_lo_o  <= w_acc_next[N_BITS-1:0];
          end
        end
        default: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
